fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Prefetch buffer between the instruction-fetch stage (program counter, instruction memory, PC+4 adder) and the decode stage.
- Stores {pc, instruction} pairs in order, so fetch can run ahead of decode and decode stalls do not stall the PC.
- Flushed on a control-flow redirect (branch/jump) so no stale sequential instructions reach decode.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- XLEN, 32, width of pc and instruction fields.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  redirect; discards all entries.
- push_valid  input  1  fetch presents an entry.
- push_ready  output  1  queue can accept an entry.
- push_pc  input  XLEN  PC of the fetched instruction.
- push_instr  input  XLEN  fetched instruction word.
- pop_valid  output  1  head entry available to decode.
- pop_ready  input  1  decode consumes the head entry.
- pop_pc  output  XLEN  PC of the head entry.
- pop_instr  output  XLEN  instruction of the head entry.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): count=0, read/write pointers=0, pop_valid=0, push_ready=1, pop_pc=0, pop_instr=0.
- Storage contents are not reset.
- Push fires when push_valid && push_ready; the entry is written at the write pointer on the rising edge.
- Pop fires when pop_valid && pop_ready; the read pointer advances on the rising edge.
- push_ready = (count != DEPTH). It does not depend on pop_ready, so there is no combinational path from decode to fetch. Consequence: a full queue rejects a push even in a cycle that pops.
- pop_valid = (count != 0). pop_pc/pop_instr are read combinationally from the head entry.
- pop_pc and pop_instr are forced to 0 whenever pop_valid=0.
- Latency: an entry pushed in cycle N is visible at the pop outputs in cycle N+1. There is no same-cycle bypass when the queue is empty.
- Simultaneous push and pop with 0<count<DEPTH: both fire and count is unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally (mod DEPTH).
- count saturates logically: it cannot exceed DEPTH or go below 0 by construction, and the bench asserts this.
- flush is synchronous and dominant. On the clock edge with flush=1:
  - count and both pointers go to 0.
  - A push or pop handshake in that cycle has no effect on state.
  - Decode must ignore any head entry sampled in a flush cycle.
- After flush, pop_valid=0 in the next cycle. push_ready=1 in the flush cycle's successor. push_ready is not gated by flush combinationally.
- Reset asserted mid-operation: state is cleared immediately, regardless of clock. Deassertion is expected to be synchronised externally.
- Push while full (push_valid=1, push_ready=0): no write, no state change.
- Pop while empty: no state change.

Decomposition:
- Shared CPU package:
  - XLEN=32 constant.
  - Packed typedef fq_entry_t {pc[XLEN], instr[XLEN]}.
  - NOP instruction constant, for decode's use when pop_valid=0.
- One natural sub-module: fetch_queue_mem, a DEPTH x 2*XLEN register array with one synchronous write port and one asynchronous read port.
- Pointer/count control stays in fetch_queue.

Test Plan:
- Reset then idle: after rst_n rises, expect count=0, pop_valid=0, push_ready=1, pop_pc=0, pop_instr=0 for 5 cycles.
- Fill to full: push pc=0x00,0x04,0x08,0x0C with instr=0xA0..0xA3 and pop_ready=0. Expect count=4, push_ready=0. A 5th push (pc=0x10) is rejected. Then pop 4 times: expect pcs 0x00,0x04,0x08,0x0C in order, then pop_valid=0.
- Streaming: push_valid=1 and pop_ready=1 continuously, pc incrementing by 4 from 0x100 for 20 cycles. Expect count to hold at 1 after the first cycle, pop_pc to lag push_pc by exactly one cycle, and no gaps. This also covers pointer wrap.
- Flush: load 3 entries (pc 0x20,0x24,0x28), assert flush together with push pc=0x2C. Next cycle expect count=0, pop_valid=0. Then push pc=0x80 and expect pop_pc=0x80 the following cycle.
- Full plus simultaneous pop: with count=4, assert push_valid (pc=0x40) and pop_ready. Expect the pop to fire, the push to be rejected, count=3, and push_ready=1 next cycle.
- Asynchronous reset mid-stream: with count=2, drop rst_n between clock edges. Expect pop_valid=0 and count=0 before the next edge, and no entries remaining after release.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared CPU constants and entry type for the fetch queue
package fetch_queue_pkg;

    localparam int FQ_XLEN  = 32;
    localparam int FQ_DEPTH = 4;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] instr;
    } fq_entry_t;

    // addi x0, x0, 0: what decode issues while the queue has nothing valid
    localparam logic [FQ_XLEN-1:0] FQ_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue_mem.sv
// rtl/fetch_queue_mem.sv - DEPTH x WIDTH register array, one sync write, one async read
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Contents are deliberately left unreset; occupancy tracking guards reads.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order {pc, instr} prefetch buffer between fetch and decode
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int XLEN  = FQ_XLEN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [XLEN-1:0]            push_pc,
    input  logic [XLEN-1:0]            push_instr,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [XLEN-1:0]            pop_pc,
    output logic [XLEN-1:0]            pop_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_fire, pop_fire, wr_en;
    logic [2*XLEN-1:0] head;

    // push_ready looks only at occupancy so decode never reaches fetch combinationally.
    assign push_ready = (count_q != CW'(DEPTH));
    assign pop_valid  = (count_q != '0);
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop_valid && pop_ready;
    assign wr_en      = push_fire && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_fire) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_fire) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data ({push_pc, push_instr}),
        .rd_addr (rd_ptr_q),
        .rd_data (head)
    );

    assign pop_pc    = pop_valid ? head[2*XLEN-1:XLEN] : '0;
    assign pop_instr = pop_valid ? head[XLEN-1:0]      : '0;
    assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [31:0] push_pc = '0;
    logic [31:0] push_instr = '0;
    logic        pop_valid;
    logic        pop_ready = 1'b0;
    logic [31:0] pop_pc;
    logic [31:0] pop_instr;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;
    fq_entry_t exp_q[$];

    fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_pc    (push_pc),
        .push_instr (push_instr),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_pc     (pop_pc),
        .pop_instr  (pop_instr),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; acc marks a push this bench expects to be accepted.
    task automatic cyc(input logic pv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic pr, input logic fl, input logic acc);
        fq_entry_t e;
        push_valid = pv;
        push_pc    = pc;
        push_instr = ins;
        pop_ready  = pr;
        flush      = fl;
        if (fl) exp_q.delete();
        if (acc) begin
            e.pc    = pc;
            e.instr = ins;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
    endtask

    // Monitor: every pop handshake outside flush/reset is compared against the scoreboard.
    always @(negedge clk) begin
        fq_entry_t e;
        checks++;
        if (count > 3'(DEPTH)) begin
            failures++;
            $display("FAIL count_bound actual=%0d required<=%0d", count, DEPTH);
        end
        if (rst_n && !flush && pop_valid && pop_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected actual=%0h required=none", pop_pc);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", pop_pc, e.pc);
                chk("pop_instr", pop_instr, e.instr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("idle_count", 32'(count), 32'd0);
            chk("idle_pop_valid", 32'(pop_valid), 32'd0);
            chk("idle_push_ready", 32'(push_ready), 32'd1);
            chk("idle_pop_pc", pop_pc, 32'd0);
            chk("idle_pop_instr", pop_instr, 32'd0);
        end

        // Fill to full, reject a 5th push, drain in order
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'(i*4), 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b1);
            chk("fill_count", 32'(count), 32'(i+1));
        end
        chk("full_push_ready", 32'(push_ready), 32'd0);
        cyc(1'b1, 32'h10, 32'hA4, 1'b0, 1'b0, 1'b0);
        chk("full_reject_count", 32'(count), 32'd4);
        chk("full_head_pc", pop_pc, 32'h00);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("drain_pop_valid", 32'(pop_valid), 32'd0);
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);

        // Streaming with pointer wrap
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 32'h100 + 32'(4*i), 32'hB00 + 32'(i), 1'b1, 1'b0, 1'b1);
            chk("stream_count", 32'(count), 32'd1);
            chk("stream_lag_pc", pop_pc, 32'h100 + 32'(4*i));
        end
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("stream_end_count", 32'(count), 32'd0);
        chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);

        // Flush with a concurrent push and pop
        cyc(1'b1, 32'h20, 32'hC0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h24, 32'hC1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h28, 32'hC2, 1'b0, 1'b0, 1'b1);
        chk("preflush_count", 32'(count), 32'd3);
        cyc(1'b1, 32'h2C, 32'hC3, 1'b1, 1'b1, 1'b0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_pop_valid", 32'(pop_valid), 32'd0);
        chk("flush_push_ready", 32'(push_ready), 32'd1);
        chk("flush_pop_pc", pop_pc, 32'd0);
        cyc(1'b1, 32'h80, 32'hC8, 1'b0, 1'b0, 1'b1);
        chk("postflush_pop_pc", pop_pc, 32'h80);
        chk("postflush_count", 32'(count), 32'd1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Full plus simultaneous pop: pop fires, push rejected
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h30 + 32'(4*i), 32'hD0 + 32'(i), 1'b0, 1'b0, 1'b1);
        chk("full2_count", 32'(count), 32'd4);
        cyc(1'b1, 32'h40, 32'hD4, 1'b1, 1'b0, 1'b0);
        chk("fullpop_count", 32'(count), 32'd3);
        chk("fullpop_push_ready", 32'(push_ready), 32'd1);
        chk("fullpop_head_pc", pop_pc, 32'h34);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("fullpop_drain_count", 32'(count), 32'd0);
        chk("fullpop_sb_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset between edges
        cyc(1'b1, 32'h50, 32'hE0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h54, 32'hE1, 1'b0, 1'b0, 1'b1);
        chk("prereset_count", 32'(count), 32'd2);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("areset_pop_valid", 32'(pop_valid), 32'd0);
        chk("areset_count", 32'(count), 32'd0);
        chk("areset_push_ready", 32'(push_ready), 32'd1);
        chk("areset_pop_pc", pop_pc, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postreset_count", 32'(count), 32'd0);
        chk("postreset_pop_valid", 32'(pop_valid), 32'd0);
        cyc(1'b1, 32'h60, 32'hF0, 1'b0, 1'b0, 1'b1);
        chk("postreset_head_pc", pop_pc, 32'h60);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("final_count", 32'(count), 32'd0);
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
